// File: rtl/lsu_axil_master.sv
// rtl/lsu_axil_master.sv - load/store unit AXI-lite bus master, one outstanding access
module lsu_axil_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_misalign,
  output logic        mem_awvalid,
  output logic [31:0] mem_awaddr,
  input  logic        mem_awready,
  output logic        mem_wvalid,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_wready,
  input  logic        mem_bvalid,
  input  logic [1:0]  mem_bresp,
  output logic        mem_bready,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_next;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        misalign;
  logic [3:0]  mask;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Size 3 is reserved and always rejected along with unaligned halves/words
  assign misalign = (req_size == 2'd3) ||
                    ((req_size == 2'd1) && req_addr[0]) ||
                    ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  // Byte-enable pattern before lane steering
  always_comb begin
    mask = 4'b0000;
    case (req_size)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      2'd2:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  // Move the addressed lane down to bit 0 and extend it to 32 bits
  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'd0:    load_data = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state selection; completion handshakes win over address handshakes
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = misalign ? RESP : (req_wen ? WR : RD);
      RD:   if (mem_rvalid && mem_rready) state_next = RESP;
      WR:   if (mem_bvalid && mem_bready) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered bus channel signals and response fields
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q         <= 2'd0;
      size_q        <= 2'd0;
      uns_q         <= 1'b0;
      mem_awvalid   <= 1'b0;
      mem_awaddr    <= 32'd0;
      mem_wvalid    <= 1'b0;
      mem_wdata     <= 32'd0;
      mem_wstrb     <= 8'd0;
      mem_bready    <= 1'b0;
      mem_arvalid   <= 1'b0;
      mem_araddr    <= 32'd0;
      mem_rready    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
      resp_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q         <= req_addr[1:0];
            size_q        <= req_size;
            uns_q         <= req_unsigned;
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b0;
            resp_misalign <= misalign;
            if (!misalign) begin
              if (req_wen) begin
                mem_awaddr  <= {req_addr[31:2], 2'b00};
                mem_wdata   <= req_wdata << {req_addr[1:0], 3'b000};
                mem_wstrb   <= {4'b0000, mask << req_addr[1:0]};
                mem_awvalid <= 1'b1;
                mem_wvalid  <= 1'b1;
                mem_bready  <= 1'b1;
              end else begin
                mem_araddr  <= {req_addr[31:2], 2'b00};
                mem_arvalid <= 1'b1;
                mem_rready  <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (mem_rvalid && mem_rready) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            resp_err    <= (mem_rresp != 2'b00);
            resp_rdata  <= (mem_rresp != 2'b00) ? 32'd0 : load_data;
          end else if (mem_arready) begin
            mem_arvalid <= 1'b0;
          end
        end
        WR: begin
          if (mem_bvalid && mem_bready) begin
            mem_awvalid <= 1'b0;
            mem_wvalid  <= 1'b0;
            mem_bready  <= 1'b0;
            resp_err    <= (mem_bresp != 2'b00);
          end else begin
            if (mem_awready) mem_awvalid <= 1'b0;
            if (mem_wready)  mem_wvalid  <= 1'b0;
          end
        end
        RESP: begin
          resp_rdata    <= 32'd0;
          resp_err      <= 1'b0;
          resp_misalign <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axil_master.sv
// tb/tb_lsu_axil_master.sv - directed self-checking bench for lsu_axil_master
module tb_lsu_axil_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid, resp_err, resp_misalign;
  logic [31:0] resp_rdata;
  logic        mem_awvalid, mem_awready = 1'b0;
  logic [31:0] mem_awaddr;
  logic        mem_wvalid, mem_wready = 1'b0;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_bvalid = 1'b0, mem_bready;
  logic [1:0]  mem_bresp = 2'd0;
  logic        mem_arvalid, mem_arready = 1'b0;
  logic [31:0] mem_araddr;
  logic        mem_rvalid = 1'b0, mem_rready;
  logic [31:0] mem_rdata = 32'd0;
  logic [1:0]  mem_rresp = 2'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_axil_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_misalign(resp_misalign),
    .mem_awvalid(mem_awvalid), .mem_awaddr(mem_awaddr), .mem_awready(mem_awready),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_wready(mem_wready),
    .mem_bvalid(mem_bvalid), .mem_bresp(mem_bresp), .mem_bready(mem_bready),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rready(mem_rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if ({mem_awvalid, mem_wvalid, mem_bready, mem_arvalid, mem_rready} !== 5'b0) begin errors++; $display("FAIL reset_mem_ctrl got %b exp 00000", {mem_awvalid, mem_wvalid, mem_bready, mem_arvalid, mem_rready}); end
    checks++; if ({mem_awaddr, mem_araddr, mem_wdata, mem_wstrb} !== 104'd0) begin errors++; $display("FAIL reset_mem_data got %h exp 0", {mem_awaddr, mem_araddr, mem_wdata, mem_wstrb}); end
  endtask

  // Load with arready given one cycle after arvalid, then rvalid on the following cycle
  task automatic run_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] rdata, input logic [31:0] exp_araddr,
                          input logic [31:0] exp_rdata);
    issue(1'b0, addr, 32'd0, size, uns);
    checks++; if ({mem_arvalid, mem_rready, req_ready} !== 3'b110) begin errors++; $display("FAIL %s_ar_issue got %b exp 110", name, {mem_arvalid, mem_rready, req_ready}); end
    checks++; if (mem_araddr !== exp_araddr) begin errors++; $display("FAIL %s_araddr got %h exp %h", name, mem_araddr, exp_araddr); end
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    checks++; if ({mem_arvalid, mem_rready, resp_valid} !== 3'b010) begin errors++; $display("FAIL %s_ar_done got %b exp 010", name, {mem_arvalid, mem_rready, resp_valid}); end
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_rresp = 2'd0;
    tick();
    mem_rvalid = 1'b0;
    checks++; if ({resp_valid, resp_err, resp_misalign} !== 3'b100) begin errors++; $display("FAIL %s_resp_flags got %b exp 100", name, {resp_valid, resp_err, resp_misalign}); end
    checks++; if (resp_rdata !== exp_rdata) begin errors++; $display("FAIL %s_rdata got %h exp %h", name, resp_rdata, exp_rdata); end
    tick();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL %s_back_idle got %b exp 01", name, {resp_valid, req_ready}); end
  endtask

  task automatic test_loads();
    run_load("ld_word",  32'h8000_0004, 2'd2, 1'b0, 32'h1234_5678, 32'h8000_0004, 32'h1234_5678);
    run_load("ld_byte_s", 32'h8000_0003, 2'd0, 1'b0, 32'h80FF_0000, 32'h8000_0000, 32'hFFFF_FF80);
    run_load("ld_byte_u", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_0000, 32'h8000_0000, 32'h0000_0080);
    run_load("ld_half_s", 32'h8000_0002, 2'd1, 1'b0, 32'h8001_1234, 32'h8000_0000, 32'hFFFF_8001);
  endtask

  task automatic test_store_half();
    issue(1'b1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 1'b0);
    checks++; if ({mem_awvalid, mem_wvalid, mem_bready, mem_arvalid} !== 4'b1110) begin errors++; $display("FAIL st_issue got %b exp 1110", {mem_awvalid, mem_wvalid, mem_bready, mem_arvalid}); end
    checks++; if (mem_awaddr !== 32'h8000_0000) begin errors++; $display("FAIL st_awaddr got %h exp 80000000", mem_awaddr); end
    checks++; if (mem_wdata !== 32'hABCD_0000) begin errors++; $display("FAIL st_wdata got %h exp abcd0000", mem_wdata); end
    checks++; if (mem_wstrb !== 8'h0C) begin errors++; $display("FAIL st_wstrb got %h exp 0c", mem_wstrb); end
    mem_awready = 1'b1;
    tick();
    mem_awready = 1'b0;
    checks++; if ({mem_awvalid, mem_wvalid, mem_bready} !== 3'b011) begin errors++; $display("FAIL st_aw_done got %b exp 011", {mem_awvalid, mem_wvalid, mem_bready}); end
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    checks++; if ({mem_awvalid, mem_wvalid, mem_bready, resp_valid} !== 4'b0010) begin errors++; $display("FAIL st_w_done got %b exp 0010", {mem_awvalid, mem_wvalid, mem_bready, resp_valid}); end
    mem_bvalid = 1'b1; mem_bresp = 2'd0;
    tick();
    mem_bvalid = 1'b0;
    checks++; if ({resp_valid, resp_err, resp_misalign, mem_bready} !== 4'b1000) begin errors++; $display("FAIL st_resp got %b exp 1000", {resp_valid, resp_err, resp_misalign, mem_bready}); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL st_rdata got %h exp 0", resp_rdata); end
    tick();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL st_single_pulse got %b exp 01", {resp_valid, req_ready}); end
  endtask

  task automatic test_misalign();
    issue(1'b0, 32'h8000_0001, 32'd0, 2'd2, 1'b0);
    checks++; if ({resp_valid, resp_misalign, resp_err, mem_arvalid, mem_rready} !== 5'b11000) begin errors++; $display("FAIL mis_resp got %b exp 11000", {resp_valid, resp_misalign, resp_err, mem_arvalid, mem_rready}); end
    tick();
    checks++; if ({resp_valid, resp_misalign, mem_arvalid, req_ready} !== 4'b0001) begin errors++; $display("FAIL mis_after got %b exp 0001", {resp_valid, resp_misalign, mem_arvalid, req_ready}); end
  endtask

  task automatic test_read_error();
    issue(1'b0, 32'h8000_0008, 32'd0, 2'd2, 1'b0);
    tick(); tick();
    checks++; if ({mem_arvalid, mem_rready, resp_valid} !== 3'b110) begin errors++; $display("FAIL err_wait got %b exp 110", {mem_arvalid, mem_rready, resp_valid}); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_rresp = 2'd2;
    tick();
    mem_rvalid = 1'b0; mem_rresp = 2'd0;
    checks++; if ({resp_valid, resp_err, mem_arvalid, mem_rready} !== 4'b1100) begin errors++; $display("FAIL err_resp got %b exp 1100", {resp_valid, resp_err, mem_arvalid, mem_rready}); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL err_rdata got %h exp 0", resp_rdata); end
    tick();
  endtask

  task automatic test_reset_in_wr();
    issue(1'b1, 32'h8000_0010, 32'h1122_3344, 2'd2, 1'b0);
    checks++; if ({mem_awvalid, mem_wvalid, mem_bready} !== 3'b111) begin errors++; $display("FAIL rstwr_issue got %b exp 111", {mem_awvalid, mem_wvalid, mem_bready}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({mem_awvalid, mem_wvalid, mem_bready, req_ready, resp_valid} !== 5'b00010) begin errors++; $display("FAIL rstwr_after got %b exp 00010", {mem_awvalid, mem_wvalid, mem_bready, req_ready, resp_valid}); end
    mem_bvalid = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rstwr_late_b got %b exp 01", {resp_valid, req_ready}); end
  endtask

  // Request held through RESP is only taken in the following IDLE cycle; rvalid with arready completes
  task automatic test_back_to_back();
    issue(1'b0, 32'h0000_0000, 32'd0, 2'd3, 1'b0);
    checks++; if ({resp_valid, resp_misalign} !== 2'b11) begin errors++; $display("FAIL b2b_size3 got %b exp 11", {resp_valid, resp_misalign}); end
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0020; req_size = 2'd2;
    tick();
    checks++; if ({mem_arvalid, req_ready, resp_valid} !== 3'b010) begin errors++; $display("FAIL b2b_resp_ignored got %b exp 010", {mem_arvalid, req_ready, resp_valid}); end
    tick();
    req_valid = 1'b0;
    checks++; if ({mem_arvalid, mem_araddr} !== {1'b1, 32'h8000_0020}) begin errors++; $display("FAIL b2b_accept got %h exp 180000020", {mem_arvalid, mem_araddr}); end
    mem_arready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_arready = 1'b0; mem_rvalid = 1'b0;
    checks++; if ({resp_valid, mem_arvalid, resp_rdata} !== {2'b10, 32'hCAFE_F00D}) begin errors++; $display("FAIL b2b_same_cycle got %h exp 2cafef00d", {resp_valid, mem_arvalid, resp_rdata}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_half();
    test_misalign();
    test_read_error();
    test_reset_in_wr();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
